// File: rtl/n_term_single2_regturn_if.sv
// Edge wire bundle for the single2 north terminator: northbound arrivals and
// the southbound wires they are turned back into.
interface n_term_single2_regturn_if;
    logic [3:0]  N1END;
    logic [7:0]  N2MID;
    logic [7:0]  N2END;
    logic [15:0] N4END;
    logic [3:0]  S1BEG;
    logic [7:0]  S2BEG;
    logic [7:0]  S2BEGb;
    logic [15:0] S4BEG;

    modport master (
        output N1END, N2MID, N2END, N4END,
        input  S1BEG, S2BEG, S2BEGb, S4BEG
    );

    modport slave (
        input  N1END, N2MID, N2END, N4END,
        output S1BEG, S2BEG, S2BEGb, S4BEG
    );
endinterface

// File: rtl/n_term_single2_regturn.sv
// North-edge single2 turnaround tile: per-group bypass/registered/low/hold modes
// loaded from a config frame. Define N_TERM_ACT_CNT_EN to build the activity counter.
module n_term_single2_regturn #(
    parameter int MaxFramesPerCol = 20,
    parameter int FrameBitsPerRow = 32,
    parameter int CFG_FRAME       = 0,
    parameter int CNT_W           = 16
) (
    input  logic                       UserCLK,
    input  logic                       resetn,
    n_term_single2_regturn_if.slave    wires,
    input  logic [FrameBitsPerRow-1:0] FrameData,
    input  logic [MaxFramesPerCol-1:0] FrameStrobe,
    input  logic                       ClrCount,
    output logic [CNT_W-1:0]           ActCount
);

    typedef enum logic [1:0] {
        MODE_BYPASS = 2'b00,
        MODE_REG    = 2'b01,
        MODE_LOW    = 2'b10,
        MODE_HOLD   = 2'b11
    } mode_e;

    logic [7:0]  mode_q, mode_d;
    logic [35:0] r_q, r_d;
    logic [35:0] in_cat;
    logic [35:0] out_cat;

    // Bit positions in the concatenation: group0 [3:0], 1 [11:4], 2 [19:12], 3 [35:20].
    function automatic int unsigned grp_of(input int unsigned i);
        if (i < 4)       return 0;
        else if (i < 12) return 1;
        else if (i < 20) return 2;
        else             return 3;
    endfunction

    assign in_cat = {wires.N4END, wires.N2END, wires.N2MID, wires.N1END};

    always_comb begin
        mode_d = mode_q;
        if (FrameStrobe[CFG_FRAME]) mode_d = FrameData[7:0];
    end

    always_comb begin
        mode_e m;
        r_d     = r_q;
        out_cat = '0;
        for (int unsigned i = 0; i < 36; i++) begin
            m = mode_e'(mode_q[2*grp_of(i) +: 2]);
            if (m != MODE_HOLD) r_d[i] = in_cat[i];
            case (m)
                MODE_BYPASS: out_cat[i] = in_cat[i];
                MODE_REG:    out_cat[i] = r_q[i];
                MODE_LOW:    out_cat[i] = 1'b0;
                MODE_HOLD:   out_cat[i] = r_q[i];
                default:     out_cat[i] = 1'b0;
            endcase
        end
    end

    assign wires.S1BEG  = out_cat[3:0];
    assign wires.S2BEG  = out_cat[11:4];
    assign wires.S2BEGb = out_cat[19:12];
    assign wires.S4BEG  = out_cat[35:20];

`ifdef N_TERM_ACT_CNT_EN
    logic [35:0]      p_q, p_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        p_d   = in_cat;
        cnt_d = cnt_q;
        if (ClrCount)                              cnt_d = '0;
        else if (in_cat != p_q && cnt_q != '1)     cnt_d = cnt_q + 1'b1;
    end

    assign ActCount = cnt_q;
`else
    assign ActCount = '0;
`endif

    logic unused_cfg_bits;
`ifdef N_TERM_ACT_CNT_EN
    assign unused_cfg_bits = ^{FrameData[FrameBitsPerRow-1:8], FrameStrobe};
`else
    assign unused_cfg_bits = ^{FrameData[FrameBitsPerRow-1:8], FrameStrobe, ClrCount};
`endif

    always_ff @(posedge UserCLK or negedge resetn) begin
        if (!resetn) begin
            mode_q <= '0;
            r_q    <= '0;
`ifdef N_TERM_ACT_CNT_EN
            p_q    <= '0;
            cnt_q  <= '0;
`endif
        end else begin
            mode_q <= mode_d;
            r_q    <= r_d;
`ifdef N_TERM_ACT_CNT_EN
            p_q    <= p_d;
            cnt_q  <= cnt_d;
`endif
        end
    end

endmodule

// File: doc/n_term_single2_regturn.md
Name: n_term_single2_regturn

Overview:
North-edge termination tile for the single2 routing column, the opposite end of the south terminator. Northbound wires that reach the top edge are turned back as southbound wires. Each wire group has a turnaround mode (bypass, registered, forced low or hold), set by a frame-strobed config word. An optional activity counter supports bring-up debug.

Parameters:
MaxFramesPerCol, 20, width of FrameStrobe
FrameBitsPerRow, 32, width of FrameData
CFG_FRAME, 0, FrameStrobe index that loads the mode word; must be < MaxFramesPerCol
CNT_W, 16, activity counter width

Ports:
UserCLK  in  1  fabric user clock; all state on rising edge
resetn  in  1  asynchronous active-low reset
N1END  in  4  northbound single wires arriving at the edge
N2MID  in  8  northbound double wires, mid tap
N2END  in  8  northbound double wires, end tap
N4END  in  16  northbound quad wires
S1BEG  out  4  southbound singles (group 0)
S2BEG  out  8  southbound doubles (group 1)
S2BEGb  out  8  southbound doubles, b half (group 2)
S4BEG  out  16  southbound quads (group 3)
FrameData  in  FrameBitsPerRow  config data
FrameStrobe  in  MaxFramesPerCol  config frame select
ClrCount  in  1  synchronous counter clear, level
ActCount  out  CNT_W  saturating activity count

Behaviour:
- Fixed bitwise map, no swizzle:
  - group0: N1END -> S1BEG
  - group1: N2MID -> S2BEG
  - group2: N2END -> S2BEGb
  - group3: N4END -> S4BEG
- Mode word: mode[7:0]. Group g uses mode[2g+1:2g].
  - Load: mode <= FrameData[7:0] on a rising edge when FrameStrobe[CFG_FRAME]=1.
  - Other FrameData bits and other strobes are ignored.
  - A new mode takes effect in the cycle after the load edge.
- Per-group register R_g, same width as the group:
  - Mode != 11: R_g <= input every cycle.
  - Mode == 11: R_g holds its value.
- Output per mode:
  - 00 bypass: output = input, combinational, 0 latency.
  - 01 registered: output = R_g, 1-cycle latency.
  - 10 forced low: output = 0. R_g keeps sampling.
  - 11 hold: output = R_g, frozen. Entering hold from any mode freezes the value sampled on the last edge before hold became active.
- Activity counter (when compiled in):
  - P (36 bits) <= {N4END,N2END,N2MID,N1END} every cycle.
  - toggle = (current concatenation != P).
  - On each edge:
    - if ClrCount: count <= 0
    - else if toggle and count != all-ones: count <= count + 1
    - else hold.
  - ClrCount has priority over increment. Count saturates at 2^CNT_W-1 with no wrap. ActCount = count, registered.
  - First edge after reset compares against P=0, so nonzero inputs count once.
- Reset (resetn=0, asynchronous, immediate):
  - mode=0 (all bypass); all R_g=0; P=0; count=0.
  - Outputs during reset: bypass groups pass inputs combinationally; ActCount=0.
  - Release is synchronous in effect; the first state update is the first rising edge with resetn=1.
- Reset mid-hold: hold is lost; after release the group is in bypass.
- Strobe asserted during reset: ignored.

Optional Feature:
- Macro: N_TERM_ACT_CNT_EN.
- Defined: P, the counter and ClrCount logic are built as described.
- Undefined: no P or counter flops; ActCount tied to 0; ClrCount unused. All other behaviour is identical.

Test Plan:
- Reset, then N1END=4'hA, N4END=16'h1234 -> same cycle S1BEG=4'hA, S4BEG=16'h1234 (bypass); ActCount=0 during reset.
- Strobe FrameStrobe[0] with FrameData=32'h0000_0001, then N1END 4'h3 -> 4'h5 -> S1BEG follows one cycle late; other groups stay combinational.
- FrameData=32'h0000_00C0 loaded while N4END=16'hBEEF, then N4END=16'h0000 -> S4BEG stays 16'hBEEF; reload 0x00 -> S4BEG=16'h0000.
- FrameData=32'h0000_0020, N2END=8'hFF -> S2BEGb=0. Strobe FrameStrobe[1] with FrameData=0 -> no mode change.
- Feature on: toggle N2MID every cycle for 10 cycles, then hold steady 5 cycles -> ActCount=10. ClrCount together with a toggle -> 0 next cycle. With CNT_W=4 and 20 toggles -> saturates at 15.
- In hold mode, assert resetn=0 mid-cycle -> R_g and ActCount go to 0 immediately and the outputs revert to bypass.
